// File: rtl/jtopl_wrqueue_pkg.sv
// Shared jtopl timing constants and replay FSM state type.
package jtopl_wrqueue_pkg;

    // YM3812 minimum idle time after each port write, in cen ticks
    localparam int unsigned JTOPL_ADDR_WAIT = 12;
    localparam int unsigned JTOPL_DATA_WAIT = 84;

    typedef enum logic {
        WQ_IDLE = 1'b0,
        WQ_WAIT = 1'b1
    } wq_state_e;

endpackage

// File: rtl/jtopl_wrqueue_fifo.sv
// Generic synchronous FIFO with a combinational head read.
module jtopl_fifo #(
    parameter int unsigned DW = 9,
    parameter int unsigned AW = 3
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // a push into a full FIFO lands in the slot being popped on the same clk
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];
    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_wrqueue.sv
// CPU write queue in front of jtopl_mmr: captures bus writes and replays them
// paced by the YM3812 address/data wait times.
module jtopl_wrqueue
    import jtopl_wrqueue_pkg::*;
#(
    parameter int unsigned AW        = 3,
    parameter int unsigned ADDR_WAIT = JTOPL_ADDR_WAIT,
    parameter int unsigned DATA_WAIT = JTOPL_DATA_WAIT,
    parameter int unsigned CW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] cpu_din,
    input  logic       cpu_addr,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic [7:0] din,
    output logic       addr,
    output logic       write
);

    logic          we;
    logic          we_l;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [8:0]    head;
    logic [AW:0]   fcount;
    logic [AW:0]   fcount_next;
    logic          fempty;
    logic          ffull;
    wq_state_e     state;
    logic [CW-1:0] cnt;

    assign we      = ~cpu_cs_n & ~cpu_wr_n;
    assign push    = we & ~we_l;
    assign pop     = (state == WQ_IDLE) & ~fempty;
    assign push_ok = push & (~ffull | pop);
    assign full    = ffull;

    jtopl_fifo #(
        .DW (9),
        .AW (AW)
    ) u_fifo (
        .rst   (rst),
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .wdata ({cpu_addr, cpu_din}),
        .rdata (head),
        .count (fcount),
        .full  (ffull),
        .empty (fempty)
    );

    // occupancy after this clk, so busy reflects the post-edge state
    always_comb begin
        fcount_next = fcount;
        if (push_ok && !pop)      fcount_next = fcount + 1'b1;
        else if (!push_ok && pop) fcount_next = fcount - 1'b1;
    end

    // write strobe edge detector; reset high so a held strobe needs a release first
    always_ff @(posedge clk) begin
        if (rst) we_l <= 1'b1;
        else      we_l <= we;
    end

    // replay FSM with wait counter, overflow flag and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WQ_IDLE;
            cnt   <= '0;
            write <= 1'b0;
            din   <= '0;
            addr  <= 1'b0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push && ffull && !pop) ovf <= 1'b1;
            case (state)
                WQ_IDLE: begin
                    if (!fempty) begin
                        {addr, din} <= head;
                        write       <= 1'b1;
                        cnt         <= head[8] ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                        state       <= WQ_WAIT;
                        busy        <= 1'b1;
                    end else begin
                        write <= 1'b0;
                        busy  <= (fcount_next != '0);
                    end
                end
                WQ_WAIT: begin
                    write <= 1'b0;
                    if (cnt == '0) begin
                        state <= WQ_IDLE;
                        busy  <= (fcount_next != '0);
                    end else begin
                        if (cen) cnt <= cnt - 1'b1;
                        busy <= 1'b1;
                    end
                end
                default: state <= WQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// Self-checking bench for jtopl_wrqueue: queue-based reference model plus
// directed scenarios with hand-computed timing and values.
module tb_jtopl_wrqueue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [7:0] cpu_din;
    logic       cpu_addr;
    logic       cpu_cs_n;
    logic       cpu_wr_n;
    logic       busy, full, ovf, addr, write;
    logic [7:0] din;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cen_total = 0;
    int cen_div = 0;

    // strobe log
    int         log_cyc[$];
    int         log_cen[$];
    logic [8:0] log_val[$];

    // reference model state
    logic [8:0] q[$];
    bit         model_ok = 0;
    bit         gate_open;
    int         cen_since;
    int         wait_len;
    bit         we_prev;
    logic       m_write, m_addr, m_ovf, m_busy;
    logic [7:0] m_din;

    jtopl_wrqueue #(
        .AW        (3),
        .ADDR_WAIT (12),
        .DATA_WAIT (84),
        .CW        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cpu_din  (cpu_din),
        .cpu_addr (cpu_addr),
        .cpu_cs_n (cpu_cs_n),
        .cpu_wr_n (cpu_wr_n),
        .busy     (busy),
        .full     (full),
        .ovf      (ovf),
        .din      (din),
        .addr     (addr),
        .write    (write)
    );

    always #5 clk = ~clk;

    initial cen = 1'b1;
    always @(negedge clk) cen = (cen_div == 0) ? 1'b1 : ((cyc % 4) == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a write leaves the queue as soon as the gate is open; after a write
    // the gate stays shut until the wait length in cen ticks has elapsed, then
    // opens on one further clock.
    always @(posedge clk) begin
        bit         we, edge_det;
        logic [8:0] h;
        cyc++;
        if (cen) cen_total++;
        if (rst) begin
            q.delete();
            gate_open = 1;
            cen_since = 0;
            wait_len  = 0;
            we_prev   = 1;
            m_write = 0; m_addr = 0; m_din = 0; m_ovf = 0; m_busy = 0;
            model_ok = 1;
        end else begin
            we       = !cpu_cs_n && !cpu_wr_n;
            edge_det = we && !we_prev;
            we_prev  = we;
            if (!gate_open) begin
                m_write = 0;
                if (cen_since >= wait_len) gate_open = 1;
                else if (cen) cen_since++;
            end else if (q.size() != 0) begin
                h = q.pop_front();
                m_write   = 1;
                m_addr    = h[8];
                m_din     = h[7:0];
                gate_open = 0;
                cen_since = 0;
                wait_len  = h[8] ? 84 : 12;
            end else begin
                m_write = 0;
            end
            if (edge_det) begin
                if (q.size() < 8) q.push_back({cpu_addr, cpu_din});
                else m_ovf = 1;
            end
            m_busy = (q.size() != 0) || !gate_open || m_write;
        end
    end

    // Per-cycle comparison against the model, and strobe logging
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            chk("write", write, m_write);
            chk("busy", busy, m_busy);
            chk("full", full, (q.size() == 8));
            chk("ovf", ovf, m_ovf);
            chk("din", din, m_din);
            chk("addr", addr, m_addr);
        end
        if (write === 1'b1) begin
            log_cyc.push_back(cyc);
            log_cen.push_back(cen_total);
            log_val.push_back({addr, din});
        end
    end

    task automatic clear_log();
        log_cyc.delete();
        log_cen.delete();
        log_val.delete();
    endtask

    // one CPU write; pc returns the cycle number of the capturing edge
    task automatic cpu_write(input logic a, input logic [7:0] d, output int pc);
        @(negedge clk);
        cpu_cs_n = 0; cpu_wr_n = 0; cpu_addr = a; cpu_din = d;
        @(posedge clk);
        #1 pc = cyc;
        @(negedge clk);
        cpu_cs_n = 1; cpu_wr_n = 1;
    endtask

    // wait until busy drops; fc is the cycle of the edge after which it is low
    task automatic wait_idle(input int bound, output int fc);
        fc = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) begin
                fc = cyc;
                break;
            end
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int pc, p2, fc, d;
        rst = 1; cpu_cs_n = 1; cpu_wr_n = 1; cpu_addr = 0; cpu_din = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_din", din, 0);
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);

        // 1) single address write
        clear_log();
        cpu_write(0, 8'h20, pc);
        wait_idle(200, fc);
        chk("t1_nstrobe", log_cyc.size(), 1);
        if (log_cyc.size() >= 1) begin
            chk("t1_latency", log_cyc[0] - pc, 1);
            chk("t1_val", log_val[0], 9'h020);
        end
        chk("t1_busy_fall", fc - pc, 14);

        // 2) address then data
        clear_log();
        cpu_write(0, 8'hA0, pc);
        cpu_write(1, 8'h55, p2);
        wait_idle(400, fc);
        chk("t2_nstrobe", log_cyc.size(), 2);
        if (log_cyc.size() >= 2) begin
            chk("t2_spacing", log_cyc[1] - log_cyc[0], 14);
            chk("t2_val0", log_val[0], 9'h0A0);
            chk("t2_val1", log_val[1], 9'h155);
            chk("t2_busy_fall", fc - log_cyc[1], 85);
        end

        // 3) quarter-rate cen, data write pacing
        cen_div = 1;
        clear_log();
        cpu_write(1, 8'h11, pc);
        cpu_write(1, 8'h22, p2);
        wait_idle(1200, fc);
        chk("t3_nstrobe", log_cyc.size(), 2);
        if (log_cyc.size() >= 2) begin
            d = log_cyc[1] - log_cyc[0];
            chk("t3_spacing_range", (d >= 335 && d <= 338), 1);
            chk("t3_cen_ticks", (log_cen[1] - log_cen[0] >= 84), 1);
            chk("t3_val1", log_val[1], 9'h122);
        end
        cen_div = 0;
        repeat (2) @(negedge clk);

        // 4) overflow while the first data wait runs
        clear_log();
        cpu_write(1, 8'h01, pc);
        for (int i = 0; i < 9; i++) cpu_write(i[0], 8'h30 + 8'(i), p2);
        @(posedge clk);
        #1;
        chk("t4_ovf", ovf, 1);
        chk("t4_full", full, 1);
        wait_idle(2000, fc);
        chk("t4_nstrobe", log_cyc.size(), 9);
        if (log_val.size() >= 9) begin
            chk("t4_first", log_val[0], 9'h101);
            for (int i = 1; i < 9; i++)
                chk("t4_order", log_val[i], {1'((i - 1) % 2), 8'h30 + 8'(i - 1)});
        end
        chk("t4_ovf_sticky", ovf, 1);

        // 5) long strobe pushes once; strobe held across reset pushes nothing
        clear_log();
        @(negedge clk);
        cpu_cs_n = 0; cpu_wr_n = 0; cpu_addr = 0; cpu_din = 8'h5A;
        repeat (20) @(negedge clk);
        cpu_cs_n = 1; cpu_wr_n = 1;
        wait_idle(200, fc);
        chk("t5_one_push", log_cyc.size(), 1);
        clear_log();
        @(negedge clk);
        rst = 1; cpu_cs_n = 0; cpu_wr_n = 0; cpu_din = 8'hC3;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        cpu_cs_n = 1; cpu_wr_n = 1;
        repeat (30) @(negedge clk);
        chk("t5_no_push", log_cyc.size(), 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovf_cleared", ovf, 0);

        // 6) reset during wait with queued entries
        clear_log();
        cpu_write(1, 8'h77, pc);
        cpu_write(0, 8'h01, p2);
        cpu_write(0, 8'h02, p2);
        cpu_write(1, 8'h03, p2);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        chk("t6_write", write, 0);
        chk("t6_busy", busy, 0);
        chk("t6_full", full, 0);
        @(negedge clk) rst = 0;
        repeat (120) @(negedge clk);
        chk("t6_nstrobe", log_cyc.size(), 1);
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
